signal_conflict_monitor: RTL
============================

Name: signal_conflict_monitor

Overview:
- Independent safety monitor for the intersection. It sits on the lamp-drive side of the traffic controller.
- Consumes the six NS/EW signal fields the controller drives: crossing, road and pedestrian, for both directions.
- Checks them for illegal codes, cross-direction conflicts, skipped or short yellows, and stalls.
- On any violation it latches a fault and requests red-flash operation until cleared.

Parameters:
- DEBOUNCE, 2: consecutive cycles an illegal code or conflict must persist before it faults (≥1).
- MIN_YELLOW, 4: minimum cycles a channel must be YELLOW before it may go RED (≥1).
- WATCHDOG, 200: maximum consecutive all-RED cycles in RUN before a stall fault.
- STARTUP_CYCLES, 16: length of the start-up flash after reset or clear.
- FLASH_HALF, 8: cycles per half-period of flash_phase.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ns_crossing, ns_road, ns_ped  in  3 each  NS signal fields; RED=100, YELLOW=010, GREEN=001
- ew_crossing, ew_road, ew_ped  in  3 each  EW signal fields; same encoding
- fault_clear  in  1  single-cycle clear request
- fault  out  1  latched fault flag
- fault_code  out  3  0 none, 1 ILLEGAL, 2 CONFLICT, 3 SKIP_YELLOW, 4 SHORT_YELLOW, 5 STALL
- fault_channel  out  3  offending channel 0..5 (ns_crossing, ns_road, ns_ped, ew_crossing, ew_road, ew_ped); 7 when the fault is not per-channel
- flash_req  out  1  high in STARTUP and FAULT
- flash_phase  out  1  flash square wave

Behaviour:
- Reset (synchronous, active-high):
  - state = STARTUP; fault = 0; fault_code = 0; fault_channel = 7.
  - flash_req = 1; flash_phase = 1.
  - All counters are cleared; every per-channel prev-colour register is set to RED.
- States:
  - STARTUP: checks are disabled; a counter runs 0..STARTUP_CYCLES-1; at the last count the next state is RUN.
  - RUN: all checks are active; flash_req = 0.
  - FAULT: fault = 1 and flash_req = 1; fault_code and fault_channel are frozen.
- Prev-colour registers sample all six inputs every cycle in every state. Transition checks therefore compare the registered value against the current input.
- ILLEGAL: any field not in {100, 010, 001} for DEBOUNCE consecutive cycles. fault_channel = lowest offending index.
- CONFLICT: "NS active" = any NS field ≠ RED, and the same for EW. Both directions active for DEBOUNCE consecutive cycles raises a fault with fault_channel = 7. Any non-qualifying cycle resets the debounce counter.
- SKIP_YELLOW: a channel goes from prev GREEN to current RED.
- SHORT_YELLOW: a per-channel counter saturates at MIN_YELLOW.
  - It counts cycles spent YELLOW, including the first one, and resets when the channel is not YELLOW.
  - Fault when prev = YELLOW, current = RED and count < MIN_YELLOW.
  - YELLOW→GREEN is legal.
- STALL: all six fields RED for WATCHDOG consecutive cycles; fault_channel = 7.
- Fault latching:
  - Detection in cycle N means the registered outputs show the fault in cycle N+1.
  - When several faults hit the same cycle, priority is ILLEGAL > CONFLICT > SKIP_YELLOW > SHORT_YELLOW > STALL. Within one code, the lowest channel wins.
- fault_clear:
  - In FAULT, it is accepted only if all six fields are RED in that cycle. Accepting it moves to STARTUP and clears fault, fault_code, fault_channel and all counters.
  - Otherwise it is ignored; there is no pending or queued clear.
  - It is ignored in RUN and STARTUP.
- flash_phase:
  - Toggles every FLASH_HALF cycles while flash_req = 1.
  - Held at 1 in RUN.
  - Its counter restarts on entry to STARTUP or FAULT.
- A reset mid-fault or mid-startup always wins and returns to the reset values.
- Counter widths come from $clog2 of their parameter; all counters saturate and never wrap.

Optional Feature:
- Macro: MONITOR_OVERRIDE_EN.
- Defined:
  - Adds outputs ns_crossing_o, ns_road_o, ns_ped_o, ew_crossing_o, ew_road_o and ew_ped_o, each 3 bits.
  - In RUN they pass the inputs through combinationally.
  - When flash_req = 1 they drive RED if flash_phase = 1, else 000 (dark).
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Run the normal pretimed cycle (greens 25, yellows 5, MIN_YELLOW = 4) for 3 full cycles after STARTUP → fault stays 0 and fault_code stays 0 throughout.
- Drive ns_road = GREEN and ew_road = GREEN for 2 cycles in RUN → fault = 1, fault_code = 2, fault_channel = 7. A 1-cycle overlap must not fault.
- Drive ew_crossing GREEN → YELLOW for 2 cycles → RED → fault_code = 4, fault_channel = 3. Going directly GREEN → RED instead gives fault_code = 3.
- Drive ns_ped = 3'b011 for 2 cycles while ns_crossing is simultaneously skipping yellow → fault_code = 1, fault_channel = 2.
- In FAULT, pulse fault_clear with ns_road = GREEN → no change. Pulse it again with all fields RED → STARTUP, fault = 0, RUN after 16 cycles.
- Hold all fields RED in RUN → fault_code = 5 on the cycle after 200 consecutive all-RED cycles; flash_phase toggles every 8 cycles afterwards.

Source files
------------

// File: rtl/signal_conflict_monitor.sv
// Safety monitor on the lamp-drive fields: latches illegal/conflict/yellow/stall faults and requests red-flash.
// Latency: a violation detected in cycle N is visible on the registered fault outputs in cycle N+1.
// Backpressure: none; inputs are sampled every cycle. Optional lamp override outputs under MONITOR_OVERRIDE_EN.
module signal_conflict_monitor #(
    parameter int DEBOUNCE       = 2,
    parameter int MIN_YELLOW     = 4,
    parameter int WATCHDOG       = 200,
    parameter int STARTUP_CYCLES = 16,
    parameter int FLASH_HALF     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] ns_crossing,
    input  logic [2:0] ns_road,
    input  logic [2:0] ns_ped,
    input  logic [2:0] ew_crossing,
    input  logic [2:0] ew_road,
    input  logic [2:0] ew_ped,
    input  logic       fault_clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] fault_channel,
    output logic       flash_req,
    output logic       flash_phase
`ifdef MONITOR_OVERRIDE_EN
    ,
    output logic [2:0] ns_crossing_o,
    output logic [2:0] ns_road_o,
    output logic [2:0] ns_ped_o,
    output logic [2:0] ew_crossing_o,
    output logic [2:0] ew_road_o,
    output logic [2:0] ew_ped_o
`endif
);
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int WW = $clog2(WATCHDOG + 1);
    localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE);
    localparam logic [YW-1:0] Y_MAX   = YW'(MIN_YELLOW);
    localparam logic [WW-1:0] WD_MAX  = WW'(WATCHDOG);
    localparam logic [SW-1:0] ST_LAST = SW'(STARTUP_CYCLES - 1);
    localparam logic [FW-1:0] FL_LAST = FW'(FLASH_HALF - 1);

    typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_FAULT} state_t;

    state_t                  state_q, state_d;
    logic [5:0][2:0]         fld, prev_q;
    logic [5:0][DW-1:0]      ill_cnt_q, ill_cnt_d;
    logic [5:0][YW-1:0]      ycnt_q, ycnt_d;
    logic [DW-1:0]           con_cnt_q, con_cnt_d;
    logic [WW-1:0]           wd_cnt_q, wd_cnt_d;
    logic [SW-1:0]           st_cnt_q, st_cnt_d;
    logic [FW-1:0]           fl_cnt_q, fl_cnt_d;
    logic                    fault_q, fault_d, phase_q, phase_d;
    logic [2:0]              code_q, code_d, chan_q, chan_d;
    logic [5:0]              illegal;
    logic                    all_red, ns_act, ew_act, run, clr_accept;
    logic                    det_vld;
    logic [2:0]              det_code, det_chan;

    // Channel 0 is ns_crossing, channel 5 is ew_ped.
    assign fld        = {ew_ped, ew_road, ew_crossing, ns_ped, ns_road, ns_crossing};
    assign run        = (state_q == ST_RUN);
    assign clr_accept = (state_q == ST_FAULT) && fault_clear && all_red;

    // Per-cycle classification of the six fields.
    always_comb begin
        all_red = 1'b1;
        ns_act  = 1'b0;
        ew_act  = 1'b0;
        illegal = '0;
        for (int i = 0; i < 6; i++) begin
            illegal[i] = !((fld[i] == RED) || (fld[i] == YEL) || (fld[i] == GRN));
            if (fld[i] != RED) begin
                all_red = 1'b0;
                if (i < 3) ns_act = 1'b1;
                else       ew_act = 1'b1;
            end
        end
    end

    // Saturating check counters and prioritised violation detect (later assignments win).
    always_comb begin
        con_cnt_d = '0;
        wd_cnt_d  = '0;
        ill_cnt_d = '0;
        ycnt_d    = '0;
        det_vld   = 1'b0;
        det_code  = 3'd0;
        det_chan  = 3'd7;
        if (run && ns_act && ew_act)
            con_cnt_d = (con_cnt_q == DB_MAX) ? DB_MAX : con_cnt_q + 1'b1;
        if (run && all_red)
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (run && illegal[i])
                ill_cnt_d[i] = (ill_cnt_q[i] == DB_MAX) ? DB_MAX : ill_cnt_q[i] + 1'b1;
            // Yellow timing runs in every state so a yellow begun before RUN is still timed.
            if ((fld[i] == YEL) && !clr_accept)
                ycnt_d[i] = (ycnt_q[i] == Y_MAX) ? Y_MAX : ycnt_q[i] + 1'b1;
        end
        if (run && (wd_cnt_d == WD_MAX)) begin
            det_vld = 1'b1; det_code = 3'd5; det_chan = 3'd7;
        end
        for (int i = 5; i >= 0; i--) begin
            if (run && (prev_q[i] == YEL) && (fld[i] == RED) && (ycnt_q[i] < Y_MAX)) begin
                det_vld = 1'b1; det_code = 3'd4; det_chan = 3'(i);
            end
        end
        for (int i = 5; i >= 0; i--) begin
            if (run && (prev_q[i] == GRN) && (fld[i] == RED)) begin
                det_vld = 1'b1; det_code = 3'd3; det_chan = 3'(i);
            end
        end
        if (run && (con_cnt_d == DB_MAX)) begin
            det_vld = 1'b1; det_code = 3'd2; det_chan = 3'd7;
        end
        for (int i = 5; i >= 0; i--) begin
            if (ill_cnt_d[i] == DB_MAX) begin
                det_vld = 1'b1; det_code = 3'd1; det_chan = 3'(i);
            end
        end
    end

    // Mode FSM next state, latched fault fields and flash timing.
    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        code_d   = code_q;
        chan_d   = chan_q;
        st_cnt_d = '0;
        fl_cnt_d = '0;
        phase_d  = 1'b1;
        case (state_q)
            ST_STARTUP: begin
                if (st_cnt_q == ST_LAST) state_d = ST_RUN;
                else                     st_cnt_d = st_cnt_q + 1'b1;
            end
            ST_RUN: begin
                if (det_vld) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = det_code;
                    chan_d  = det_chan;
                end
            end
            ST_FAULT: begin
                if (clr_accept) begin
                    state_d = ST_STARTUP;
                    fault_d = 1'b0;
                    code_d  = 3'd0;
                    chan_d  = 3'd7;
                end
            end
            default: state_d = ST_STARTUP;
        endcase
        // Flash counter restarts with phase high on every entry into a flashing state.
        if ((state_d != ST_RUN) && (state_d == state_q)) begin
            if (fl_cnt_q == FL_LAST) phase_d = ~phase_q;
            else begin
                fl_cnt_d = fl_cnt_q + 1'b1;
                phase_d  = phase_q;
            end
        end
    end

    // State and counter registers; reset dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_STARTUP;
            prev_q    <= {6{RED}};
            ill_cnt_q <= '0;
            ycnt_q    <= '0;
            con_cnt_q <= '0;
            wd_cnt_q  <= '0;
            st_cnt_q  <= '0;
            fl_cnt_q  <= '0;
            fault_q   <= 1'b0;
            code_q    <= 3'd0;
            chan_q    <= 3'd7;
            phase_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            prev_q    <= fld;
            ill_cnt_q <= ill_cnt_d;
            ycnt_q    <= ycnt_d;
            con_cnt_q <= con_cnt_d;
            wd_cnt_q  <= wd_cnt_d;
            st_cnt_q  <= st_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
            chan_q    <= chan_d;
            phase_q   <= phase_d;
        end
    end

    assign fault         = fault_q;
    assign fault_code    = code_q;
    assign fault_channel = chan_q;
    assign flash_req     = (state_q != ST_RUN);
    assign flash_phase   = phase_q;

`ifdef MONITOR_OVERRIDE_EN
    logic [2:0] lamp_flash;
    assign lamp_flash    = phase_q ? RED : 3'b000;
    assign ns_crossing_o = flash_req ? lamp_flash : ns_crossing;
    assign ns_road_o     = flash_req ? lamp_flash : ns_road;
    assign ns_ped_o      = flash_req ? lamp_flash : ns_ped;
    assign ew_crossing_o = flash_req ? lamp_flash : ew_crossing;
    assign ew_road_o     = flash_req ? lamp_flash : ew_road;
    assign ew_ped_o      = flash_req ? lamp_flash : ew_ped;
`endif
endmodule
